// File: rtl/config_seq_pkg.sv
// config_seq_pkg: shared state encoding and header field layout for the frame sequencer
package config_seq_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, STROBE, SKIP} seqState_t;
    localparam logic [3:0] CFG_MAGIC = 4'hA;
    localparam int MagicLsb = 28;
    localparam int CountLsb = 20;
    localparam int ColumnLsb = 8;
    localparam int IndexLsb = 0;
    localparam int ColumnWidth = 12;
endpackage

// File: rtl/config_header_decode.sv
// config_header_decode: splits a header word into fields and flags bad magic or out-of-range targets
module config_header_decode
    import config_seq_pkg::*;
#(
    parameter int MaxFramesPerCol = 20,
    parameter int NumColumns = 18
) (
    input  logic [31:0]            word,
    output logic [ColumnWidth-1:0] column,
    output logic [7:0]             index,
    output logic [7:0]             count,
    output logic                   hdrOk,
    output logic                   rangeOk
);
    assign column = word[ColumnLsb +: ColumnWidth];
    assign index = word[IndexLsb +: 8];
    assign count = word[CountLsb +: 8];
    assign hdrOk = word[MagicLsb +: 4] == CFG_MAGIC;
    // count holds N-1, so index+count is the last frame the burst touches
    assign rangeOk = column < ColumnWidth'(NumColumns) && index != 8'd0
        && ({1'b0, index} + {1'b0, count}) <= 9'(MaxFramesPerCol);
endmodule

// File: rtl/config_frame_sequencer.sv
// config_frame_sequencer: parses headers, assembles frames from the word stream and issues frame strobes
module config_frame_sequencer
    import config_seq_pkg::*;
#(
    parameter int NumberOfRows = 16,
    parameter int MaxFramesPerCol = 20,
    parameter int FrameSelectWidth = 5,
    parameter int NumColumns = 18
) (
    input  logic                                 CLK,
    input  logic                                 resetn,
    input  logic [31:0]                          WriteData,
    input  logic                                 WriteStrobe,
    output logic                                 Ready,
    input  logic                                 ClearError,
    output logic [32*NumberOfRows-1:0]           FrameData,
    output logic [FrameSelectWidth-1:0]          FrameSelect,
    output logic [$clog2(MaxFramesPerCol+1)-1:0] FrameStrobe_I,
    output logic                                 FrameStrobe,
    output logic                                 Busy,
    output logic                                 Error,
    output logic [15:0]                          FramesWritten
);
    localparam int IndexWidth = $clog2(MaxFramesPerCol+1);
    localparam int RowWidth = $clog2(NumberOfRows);
    seqState_t state, nextState;
    logic [RowWidth-1:0] rowCnt;
    logic [7:0] framesLeft;
    logic [ColumnWidth-1:0] hdrColumn;
    logic [7:0] hdrIndex, hdrCount;
    logic hdrOk, rangeOk, accept, lastRow, errSet;
    config_header_decode #(
        .MaxFramesPerCol(MaxFramesPerCol),
        .NumColumns(NumColumns)
    ) headerDecode (
        .word(WriteData),
        .column(hdrColumn),
        .index(hdrIndex),
        .count(hdrCount),
        .hdrOk(hdrOk),
        .rangeOk(rangeOk)
    );
    assign Ready = state != STROBE;
    assign Busy = state != IDLE;
    assign FrameStrobe = state == STROBE;
    assign accept = WriteStrobe && Ready;
    assign lastRow = rowCnt == RowWidth'(NumberOfRows-1);
    always_comb begin
        nextState = state;
        errSet = 1'b0;
        case (state)
            IDLE: if (accept) begin
                errSet = !(hdrOk && rangeOk);
                nextState = !hdrOk ? IDLE : rangeOk ? LOAD : SKIP;
            end
            LOAD: if (accept && lastRow) nextState = STROBE;
            STROBE: nextState = framesLeft != 8'd0 ? LOAD : IDLE;
            SKIP: if (accept && lastRow && framesLeft == 8'd0) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else state <= nextState;
    end
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            rowCnt <= '0;
            framesLeft <= '0;
            FrameData <= '0;
            FrameSelect <= '0;
            FrameStrobe_I <= '0;
            FramesWritten <= '0;
            Error <= 1'b0;
        end else begin
            Error <= errSet || (Error && !ClearError);
            case (state)
                IDLE: if (accept && hdrOk) begin
                    rowCnt <= '0;
                    framesLeft <= hdrCount;
                    // illegal targets are skipped, so the outputs keep the last legal target
                    if (rangeOk) begin
                        FrameSelect <= FrameSelectWidth'(hdrColumn);
                        FrameStrobe_I <= IndexWidth'(hdrIndex);
                    end
                end
                LOAD: if (accept) begin
                    FrameData[rowCnt*32 +: 32] <= WriteData;
                    rowCnt <= lastRow ? '0 : rowCnt + 1'b1;
                end
                STROBE: begin
                    FramesWritten <= FramesWritten + 16'd1;
                    rowCnt <= '0;
                    if (framesLeft != 8'd0) begin
                        framesLeft <= framesLeft - 8'd1;
                        FrameStrobe_I <= FrameStrobe_I + 1'b1;
                    end
                end
                SKIP: if (accept) begin
                    rowCnt <= lastRow ? '0 : rowCnt + 1'b1;
                    if (lastRow) framesLeft <= framesLeft - 8'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_config_frame_sequencer.sv
// tb_config_frame_sequencer: directed scenarios for header parsing, bursts, errors, stalls and reset
module tb_config_frame_sequencer;
    logic CLK = 1'b0;
    logic resetn = 1'b0;
    logic [31:0] WriteData = '0;
    logic WriteStrobe = 1'b0;
    logic ClearError = 1'b0;
    logic Ready, FrameStrobe, Busy, Error;
    logic [511:0] FrameData;
    logic [4:0] FrameSelect;
    logic [4:0] FrameStrobe_I;
    logic [15:0] FramesWritten;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lastAcc = 0;
    int readyOdd = 0;
    int strobeCyc[$];
    logic [4:0] strobeIdx[$];
    logic [4:0] strobeSel[$];
    logic [511:0] strobeData[$];

    config_frame_sequencer dut (
        .CLK(CLK),
        .resetn(resetn),
        .WriteData(WriteData),
        .WriteStrobe(WriteStrobe),
        .Ready(Ready),
        .ClearError(ClearError),
        .FrameData(FrameData),
        .FrameSelect(FrameSelect),
        .FrameStrobe_I(FrameStrobe_I),
        .FrameStrobe(FrameStrobe),
        .Busy(Busy),
        .Error(Error),
        .FramesWritten(FramesWritten)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // passive recorder of every strobe cycle; the tasks compare against it
    always @(negedge CLK) if (resetn) begin
        if (FrameStrobe) begin
            strobeCyc.push_back(cyc);
            strobeIdx.push_back(FrameStrobe_I);
            strobeSel.push_back(FrameSelect);
            strobeData.push_back(FrameData);
        end
        if (Ready == FrameStrobe) readyOdd++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    function automatic logic [511:0] mkFrame(input logic [31:0] base);
        logic [511:0] f;
        for (int k = 0; k < 16; k++) f[k*32 +: 32] = base + 32'(k);
        return f;
    endfunction

    task automatic sendWord(input logic [31:0] w, input int gap);
        repeat (gap) @(posedge CLK);
        @(negedge CLK);
        WriteStrobe = 1'b1;
        WriteData = w;
        for (int i = 0; i < 4 && !Ready; i++) @(negedge CLK);
        checks++;
        if (!Ready) begin
            errors++;
            $display("FAIL ready_timeout got Ready=%b want 1", Ready);
        end
        @(posedge CLK);
        #1;
        WriteStrobe = 1'b0;
        lastAcc = cyc;
    endtask

    task automatic sendWords(input logic [31:0] base, input int n, input int maxGap);
        for (int i = 0; i < n; i++) sendWord(base + 32'(i), maxGap == 0 ? 0 : int'($urandom_range(0, maxGap)));
    endtask

    task automatic checkResetValues(input string tag);
        checks++;
        if ({Ready, FrameStrobe, Busy, Error} !== 4'b1000) begin
            errors++;
            $display("FAIL %s_flags got R/S/B/E=%b want 1000", tag, {Ready, FrameStrobe, Busy, Error});
        end
        checks++;
        if (FramesWritten !== 16'd0 || FrameSelect !== 5'd0 || FrameStrobe_I !== 5'd0) begin
            errors++;
            $display("FAIL %s_regs got fw=%0d sel=%0d idx=%0d want 0 0 0", tag, FramesWritten, FrameSelect, FrameStrobe_I);
        end
        checks++;
        if (FrameData !== 512'd0) begin
            errors++;
            $display("FAIL %s_data got nonzero FrameData want 0", tag);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(negedge CLK);
        checkResetValues("reset");
        resetn = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_single_frame(input logic [15:0] fwWant);
        int s0 = strobeCyc.size();
        sendWord(32'hA000_0503, 0);
        sendWords(32'h0, 16, 0);
        repeat (3) @(negedge CLK);
        checks++;
        if (strobeCyc.size() - s0 !== 1) begin
            errors++;
            $display("FAIL single_count got %0d strobes want 1", strobeCyc.size() - s0);
        end else begin
            checks++;
            if (strobeCyc[s0] !== lastAcc) begin
                errors++;
                $display("FAIL single_latency got cyc %0d want %0d", strobeCyc[s0], lastAcc);
            end
            checks++;
            if (strobeSel[s0] !== 5'd5 || strobeIdx[s0] !== 5'd3) begin
                errors++;
                $display("FAIL single_target got sel=%0d idx=%0d want 5 3", strobeSel[s0], strobeIdx[s0]);
            end
            checks++;
            if (strobeData[s0] !== mkFrame(32'h0)) begin
                errors++;
                $display("FAIL single_data got %h want rows 0..15", strobeData[s0]);
            end
        end
        checks++;
        if (FramesWritten !== fwWant || Busy !== 1'b0 || Error !== 1'b0) begin
            errors++;
            $display("FAIL single_after got fw=%0d busy=%b err=%b want %0d 0 0", FramesWritten, Busy, Error, fwWant);
        end
    endtask

    task automatic test_burst();
        int s0 = strobeCyc.size();
        sendWord(32'hA020_0101, 0);
        sendWords(32'h100, 48, 0);
        repeat (3) @(negedge CLK);
        checks++;
        if (strobeCyc.size() - s0 !== 3) begin
            errors++;
            $display("FAIL burst_count got %0d strobes want 3", strobeCyc.size() - s0);
        end else begin
            for (int f = 0; f < 3; f++) begin
                checks++;
                if (strobeIdx[s0+f] !== 5'(f + 1) || strobeSel[s0+f] !== 5'd1) begin
                    errors++;
                    $display("FAIL burst_target%0d got sel=%0d idx=%0d want 1 %0d", f, strobeSel[s0+f], strobeIdx[s0+f], f + 1);
                end
                checks++;
                if (strobeData[s0+f] !== mkFrame(32'h100 + 32'(16*f))) begin
                    errors++;
                    $display("FAIL burst_data%0d got %h", f, strobeData[s0+f]);
                end
            end
            checks++;
            if (strobeCyc[s0+1] - strobeCyc[s0] !== 17 || strobeCyc[s0+2] - strobeCyc[s0+1] !== 17) begin
                errors++;
                $display("FAIL burst_spacing got %0d %0d want 17 17", strobeCyc[s0+1] - strobeCyc[s0], strobeCyc[s0+2] - strobeCyc[s0+1]);
            end
        end
        checks++;
        if (FramesWritten !== 16'd4 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL burst_after got fw=%0d busy=%b want 4 0", FramesWritten, Busy);
        end
    endtask

    task automatic test_bad_column();
        int s0 = strobeCyc.size();
        sendWord(32'hA000_1401, 0);
        @(negedge CLK);
        checks++;
        if (Error !== 1'b1 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL column_err got err=%b busy=%b want 1 1", Error, Busy);
        end
        sendWords(32'h200, 16, 0);
        repeat (3) @(negedge CLK);
        checks++;
        if (strobeCyc.size() - s0 !== 0 || Busy !== 1'b0 || FramesWritten !== 16'd4) begin
            errors++;
            $display("FAIL column_skip got strobes=%0d busy=%b fw=%0d want 0 0 4", strobeCyc.size() - s0, Busy, FramesWritten);
        end
        ClearError = 1'b1;
        @(negedge CLK);
        ClearError = 1'b0;
        checks++;
        if (Error !== 1'b0) begin
            errors++;
            $display("FAIL clear_error got %b want 0", Error);
        end
    endtask

    task automatic test_skip_and_magic();
        int s0 = strobeCyc.size();
        sendWord(32'hA010_0014, 0);
        sendWords(32'h300, 31, 0);
        @(negedge CLK);
        checks++;
        if (Busy !== 1'b1 || Error !== 1'b1) begin
            errors++;
            $display("FAIL skip_31 got busy=%b err=%b want 1 1", Busy, Error);
        end
        sendWord(32'h31F, 0);
        @(negedge CLK);
        checks++;
        if (Busy !== 1'b0 || strobeCyc.size() - s0 !== 0) begin
            errors++;
            $display("FAIL skip_32 got busy=%b strobes=%0d want 0 0", Busy, strobeCyc.size() - s0);
        end
        ClearError = 1'b1;
        @(negedge CLK);
        ClearError = 1'b0;
        sendWord(32'h5000_0000, 0);
        @(negedge CLK);
        checks++;
        if (Error !== 1'b1 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_magic got err=%b busy=%b want 1 0", Error, Busy);
        end
        ClearError = 1'b1;
        @(negedge CLK);
        ClearError = 1'b0;
    endtask

    task automatic test_gaps();
        int s0 = strobeCyc.size();
        int r0 = readyOdd;
        sendWord(32'hA000_0702, 2);
        sendWords(32'hC0DE_0000, 16, 3);
        repeat (4) @(negedge CLK);
        checks++;
        if (strobeCyc.size() - s0 !== 1) begin
            errors++;
            $display("FAIL gaps_count got %0d strobes want 1", strobeCyc.size() - s0);
        end else begin
            checks++;
            if (strobeData[s0] !== mkFrame(32'hC0DE_0000) || strobeSel[s0] !== 5'd7 || strobeIdx[s0] !== 5'd2) begin
                errors++;
                $display("FAIL gaps_frame got sel=%0d idx=%0d data=%h", strobeSel[s0], strobeIdx[s0], strobeData[s0]);
            end
            checks++;
            if (strobeCyc[s0] !== lastAcc) begin
                errors++;
                $display("FAIL gaps_latency got cyc %0d want %0d", strobeCyc[s0], lastAcc);
            end
        end
        checks++;
        if (readyOdd - r0 !== 0) begin
            errors++;
            $display("FAIL gaps_ready got %0d cycles with Ready==FrameStrobe want 0", readyOdd - r0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int s0 = strobeCyc.size();
        sendWord(32'hA000_0503, 0);
        sendWords(32'h900, 8, 0);
        @(negedge CLK);
        resetn = 1'b0;
        #1;
        checkResetValues("midreset");
        @(negedge CLK);
        resetn = 1'b1;
        repeat (20) @(negedge CLK);
        checks++;
        if (strobeCyc.size() - s0 !== 0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_strobe got strobes=%0d busy=%b want 0 0", strobeCyc.size() - s0, Busy);
        end
        test_single_frame(16'd1);
    endtask

    initial begin
        test_reset();
        test_single_frame(16'd1);
        test_burst();
        test_bad_column();
        test_skip_and_magic();
        test_gaps();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
